// File: rtl/cmd_sequencer.sv
// cmd_sequencer
//   Upstream feeder for command_processor. Host command/parameter bytes are
//   accepted over a valid/ready handshake into a small FIFO. Each complete
//   command is then replayed onto the processor's 8-bit command bus as an
//   unbroken burst: the opcode word, then its parameter words on consecutive
//   cycles, then GAP_CYCLES idle cycles. A command is issued only once all of
//   its words are buffered, so a burst is never interrupted.
//
// Parameters
//   DEPTH       FIFO entries (power of two, >= 4)
//   GAP_CYCLES  idle cycles (en=0) after the last word of a command (>= 1)
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   in_data     host word: opcode {x, cmd[1:0], param[4:0]}, parameter {xxx, param[4:0]}
//   in_valid    in_data valid
//   in_ready    FIFO can accept (level != DEPTH)
//   cmd_out     registered command bus {en, cmd[1:0], param[4:0]}
//   busy        burst in progress or FIFO not empty
//   level       current FIFO occupancy
//   drop_count  saturating count of discarded invalid head words
//               (present only when CMDSEQ_DROP_COUNT_EN is defined)
//
// Build option: define CMDSEQ_DROP_COUNT_EN to add the drop_count output.

module cmd_sequencer #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               cmd_out,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
`ifdef CMDSEQ_DROP_COUNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [6:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [1:0]      remaining, remaining_nxt;
    logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
    logic [7:0]      cmd_nxt;
    logic            push, pop, discard;
    logic [6:0]      head;
    logic [LW-1:0]   head_len;

    // Bit 7 of the host word carries no meaning and is not stored.
    logic            unused_in_bit7;
    assign unused_in_bit7 = in_data[7];

    assign head     = mem[rd_ptr];
    assign in_ready = (level != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign busy     = (state != WAIT) || (level != '0);

    // Total words (opcode + parameters) of the command at the FIFO head.
    always_comb begin
        head_len = '0;
        case (head[6:5])
            2'b01:   head_len = (head[4:0] == 5'h1F) ? LW'(1) : LW'(2);
            2'b10,
            2'b11:   head_len = LW'(4);
            default: head_len = '0;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        gap_cnt_nxt   = gap_cnt;
        cmd_nxt       = 8'h00;
        pop           = 1'b0;
        discard       = 1'b0;
        case (state)
            WAIT: begin
                if ((level != '0) && (head[6:5] == 2'b00)) begin
                    pop     = 1'b1;
                    discard = 1'b1;
                end else if ((level != '0) && (level >= head_len)) begin
                    // Whole command is buffered: start the burst.
                    cmd_nxt = {1'b1, head[6:0]};
                    pop     = 1'b1;
                    if (head_len == LW'(1)) begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = GW'(GAP_CYCLES);
                    end else begin
                        state_nxt     = ISSUE;
                        remaining_nxt = (head_len == LW'(2)) ? 2'd1 : 2'd3;
                    end
                end
            end
            ISSUE: begin
                // Completeness was checked in WAIT, so the head is always valid here.
                cmd_nxt       = {3'b100, head[4:0]};
                pop           = 1'b1;
                remaining_nxt = remaining - 2'd1;
                if (remaining == 2'd1) begin
                    state_nxt   = GAP;
                    gap_cnt_nxt = GW'(GAP_CYCLES);
                end
            end
            GAP: begin
                gap_cnt_nxt = gap_cnt - GW'(1);
                if (gap_cnt == GW'(1)) begin
                    state_nxt = WAIT;
                end
            end
            default: state_nxt = WAIT;
        endcase
    end

    // FIFO storage holds data only and is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data[6:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT;
            remaining <= '0;
            gap_cnt   <= '0;
            cmd_out   <= 8'h00;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            gap_cnt   <= gap_cnt_nxt;
            cmd_out   <= cmd_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef CMDSEQ_DROP_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= 8'h00;
        end else if (discard && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'h01;
        end
    end
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer. A transaction-level reference model
// holds the buffered host words in a queue and, whenever the sequencer is
// idle and a complete command is buffered, appends that command's whole
// output schedule (words plus idle gap) to a second queue that is then
// replayed one entry per clock.

module tb_cmd_sequencer;

    localparam int DEPTH      = 8;
    localparam int GAP_CYCLES = 1;
    localparam int LW         = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    cmd_out;
    logic          busy;
    logic [LW-1:0] level;
`ifdef CMDSEQ_DROP_COUNT_EN
    logic [7:0]    drop_count;
`endif

    cmd_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd_out   (cmd_out),
        .busy      (busy),
        .level     (level)
`ifdef CMDSEQ_DROP_COUNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        bit         pops;
    } ent_t;

    logic [7:0] q[$];
    ent_t       sched[$];
    logic [7:0] log_q[$];
    int         drops;
    bit         last_acc;
    logic [7:0] exp_cmd;
    int         n_asserts;
    int         n_fail;

    function automatic int cmd_len(input logic [7:0] w);
        case (w[6:5])
            2'b01:   return (w[4:0] == 5'h1F) ? 1 : 2;
            2'b10,
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("cmd_out", {8'h00, cmd_out}, {8'h00, exp_cmd});
        chk("level", 16'(level), 16'(q.size()));
        chk("in_ready", {15'd0, in_ready}, {15'd0, q.size() != DEPTH});
        chk("busy", {15'd0, busy}, {15'd0, (sched.size() != 0) || (q.size() != 0)});
`ifdef CMDSEQ_DROP_COUNT_EN
        chk("drop_count", {8'h00, drop_count}, 16'((drops > 255) ? 255 : drops));
`endif
    endtask

    // One clock: drive inputs, advance the model across the edge, check #1 later.
    task automatic step(input logic v, input logic [7:0] d);
        bit   acc;
        ent_t e;
        int   n;
        in_valid = v;
        in_data  = d;
        acc = v && (q.size() != DEPTH);
        @(posedge clk);
        if (sched.size() > 0) begin
            e = sched.pop_front();
            exp_cmd = e.val;
            if (e.pops) void'(q.pop_front());
        end else if (q.size() > 0 && q[0][6:5] == 2'b00) begin
            void'(q.pop_front());
            exp_cmd = 8'h00;
            drops++;
        end else if (q.size() > 0 && q.size() >= cmd_len(q[0])) begin
            n = cmd_len(q[0]);
            exp_cmd = {1'b1, q[0][6:0]};
            for (int i = 1; i < n; i++) sched.push_back('{val: {3'b100, q[i][4:0]}, pops: 1'b1});
            for (int g = 0; g < GAP_CYCLES; g++) sched.push_back('{val: 8'h00, pops: 1'b0});
            void'(q.pop_front());
        end else begin
            exp_cmd = 8'h00;
        end
        if (acc) q.push_back(d);
        last_acc = acc;
        #1;
        log_q.push_back(cmd_out);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bp_words [8];
        logic [7:0] bp_exp[$];
        int idx, guard, found;

        n_asserts = 0;
        n_fail    = 0;
        drops     = 0;
        exp_cmd   = 8'h00;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;

        // Reset state
        #2;
        chk("rst_cmd_out", {8'h00, cmd_out}, 16'h0000);
        chk("rst_level", 16'(level), 16'd0);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // CLEAR
        step(1'b1, 8'h3F);
        step(1'b0, 8'h00);
        chk("clear_op", {8'h00, cmd_out}, 16'h00BF);
        step(1'b0, 8'h00);
        chk("clear_gap", {8'h00, cmd_out}, 16'h0000);
        chk("clear_busy", {15'd0, busy}, 16'd0);
        idle(2);

        // DRAW_LINE with host gaps
        step(1'b1, 8'h41);
        idle(3);
        chk("line_wait", {8'h00, cmd_out}, 16'h0000);
        step(1'b1, 8'h02);
        step(1'b1, 8'h05);
        step(1'b1, 8'h06);
        chk("line_hold", {8'h00, cmd_out}, 16'h0000);
        step(1'b0, 8'h00); chk("line_w0", {8'h00, cmd_out}, 16'h00C1);
        step(1'b0, 8'h00); chk("line_w1", {8'h00, cmd_out}, 16'h0082);
        step(1'b0, 8'h00); chk("line_w2", {8'h00, cmd_out}, 16'h0085);
        step(1'b0, 8'h00); chk("line_w3", {8'h00, cmd_out}, 16'h0086);
        step(1'b0, 8'h00); chk("line_gap", {8'h00, cmd_out}, 16'h0000);
        idle(2);

        // DRAW_PIXEL with parameter masking
        step(1'b1, 8'h23);
        step(1'b1, 8'hE4);
        step(1'b0, 8'h00); chk("pix_w0", {8'h00, cmd_out}, 16'h00A3);
        step(1'b0, 8'h00); chk("pix_w1", {8'h00, cmd_out}, 16'h0084);
        idle(3);

        // Invalid head discarded, then CLEAR
        step(1'b1, 8'h05);
        step(1'b1, 8'h3F);
        chk("inv_silent", {8'h00, cmd_out}, 16'h0000);
`ifdef CMDSEQ_DROP_COUNT_EN
        chk("inv_drop", {8'h00, drop_count}, 16'd1);
`endif
        step(1'b0, 8'h00); chk("inv_clear", {8'h00, cmd_out}, 16'h00BF);
        idle(3);

        // Back-pressure: two FILL_RECT commands with in_valid held high
        bp_words = '{8'h60, 8'h01, 8'h02, 8'h03, 8'h61, 8'h01, 8'h02, 8'h03};
        log_q.delete();
        idx = 0;
        guard = 0;
        while (idx < 8 && guard < 100) begin
            step(1'b1, bp_words[idx]);
            if (last_acc) idx++;
            if (idx <= 4) chk("bp_early", {8'h00, cmd_out}, 16'h0000);
            guard++;
        end
        chk("bp_budget", 16'(idx), 16'd8);
        idle(14);
        bp_exp = '{8'hE0, 8'h81, 8'h82, 8'h83};
        for (int g = 0; g < GAP_CYCLES; g++) bp_exp.push_back(8'h00);
        bp_exp.push_back(8'hE1); bp_exp.push_back(8'h81);
        bp_exp.push_back(8'h82); bp_exp.push_back(8'h83);
        for (int g = 0; g < GAP_CYCLES; g++) bp_exp.push_back(8'h00);
        found = -1;
        for (int i = 0; i < log_q.size(); i++) begin
            if (found < 0 && log_q[i] == 8'hE0) found = i;
        end
        chk("bp_found", {15'd0, found >= 0}, 16'd1);
        if (found >= 0) begin
            for (int i = 0; i < bp_exp.size(); i++) begin
                if (found + i < log_q.size())
                    chk("bp_burst", {8'h00, log_q[found + i]}, {8'h00, bp_exp[i]});
                else
                    chk("bp_burst_len", 16'(log_q.size()), 16'(found + bp_exp.size()));
            end
        end

        // Reset mid-ISSUE
        step(1'b1, 8'h41);
        step(1'b1, 8'h02);
        step(1'b1, 8'h05);
        step(1'b1, 8'h06);
        guard = 0;
        while (cmd_out != 8'hC1 && guard < 10) begin
            step(1'b0, 8'h00);
            guard++;
        end
        chk("mid_reach_c1", {8'h00, cmd_out}, 16'h00C1);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        sched.delete();
        drops = 0;
        exp_cmd = 8'h00;
        chk("mid_rst_cmd", {8'h00, cmd_out}, 16'h0000);
        chk("mid_rst_level", 16'(level), 16'd0);
        chk("mid_rst_ready", {15'd0, in_ready}, 16'd1);
        chk("mid_rst_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00);
            chk("mid_no_param", {8'h00, cmd_out}, 16'h0000);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            logic       v;
            d = 8'($urandom);
            v = ($urandom_range(0, 3) != 0);
            step(v, d);
        end
        idle(30);
        chk("final_empty", 16'(level), 16'd0);
        chk("final_idle", {15'd0, busy}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
